// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered 32-bit ALU among NUM_REQ requesters.
// Define ALU_RR_SCHED_OPCHK_EN to answer opcodes 101..111 directly without issuing them.
module alu_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*3-1:0] req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 rsp_error,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_opcode,
  input  logic [31:0]          alu_result,
  input  logic                 alu_error,
  output logic                 busy,
  output logic [PTR_W-1:0]     grant_id
);

  localparam int unsigned CNT_W = $clog2(ALU_LAT + 1) + 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gid_q, gid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             err_q, err_d;

  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W:0]   probe;
  logic [31:0]      gnt_a, gnt_b;
  logic [2:0]       gnt_op;
  logic             gnt_skip;
  logic             op_is_logic;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    probe     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      probe = {1'b0, ptr_q} + (PTR_W + 1)'(k);
      if (probe >= (PTR_W + 1)'(NUM_REQ)) begin
        probe = probe - (PTR_W + 1)'(NUM_REQ);
      end
      if (!gnt_found && req_valid[probe[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = probe[PTR_W-1:0];
      end
    end
  end

  assign gnt_a  = req_a[32*gnt_idx +: 32];
  assign gnt_b  = req_b[32*gnt_idx +: 32];
  assign gnt_op = req_op[3*gnt_idx +: 3];

`ifdef ALU_RR_SCHED_OPCHK_EN
  assign gnt_skip = gnt_op[2] & (gnt_op[1] | gnt_op[0]);
`else
  assign gnt_skip = 1'b0;
`endif

  // The ALU leaves Error stale for logic ops, so it must not reach the requester.
  assign op_is_logic = (op_q == 3'b010) || (op_q == 3'b011) || (op_q == 3'b100);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          gid_d              = gnt_idx;
          if (gnt_skip) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            a_d     = gnt_a;
            b_d     = gnt_b;
            op_d    = gnt_op;
            cnt_d   = '0;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q == CNT_W'(ALU_LAT)) begin
          res_d   = alu_result;
          err_d   = op_is_logic ? 1'b0 : alu_error;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        rsp_valid[gid_q] = 1'b1;
        if (rsp_ready[gid_q]) begin
          ptr_d   = (gid_q == PTR_W'(NUM_REQ - 1)) ? '0 : gid_q + PTR_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign rsp_result = res_q;
  assign rsp_error  = err_q;
  assign busy       = (state_q != StIdle);
  assign grant_id   = gid_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: transaction-level scoreboard plus directed vectors.
// Honours ALU_RR_SCHED_OPCHK_EN when it is defined for the build.
module tb_alu_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ALU_LAT = 1;
  localparam int PTR_W   = 2;
`ifdef ALU_RR_SCHED_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*32-1:0] req_a, req_b;
  logic [NUM_REQ*3-1:0]  req_op;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_error, alu_error, busy;
  logic [2:0]  alu_opcode;
  logic [PTR_W-1:0] grant_id;

  logic [31:0] ra [NUM_REQ];
  logic [31:0] rb [NUM_REQ];
  logic [2:0]  rop [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign req_a[32*i +: 32] = ra[i];
    assign req_b[32*i +: 32] = rb[i];
    assign req_op[3*i +: 3]  = rop[i];
  end

  always #5 clk = ~clk;

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ALU_LAT(ALU_LAT), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_error(alu_error),
    .busy(busy), .grant_id(grant_id)
  );

  // {error, result}; error is signed overflow for add/sub, 1 for undefined opcodes
  function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic e;
    r = '0;
    e = 1'b0;
    case (op)
      3'b000: begin r = a + b; e = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin r = a - b; e = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  // One-cycle registered ALU; logic ops leave Error untouched (stale).
  logic [32:0] alu_calc;
  logic [31:0] alu_res_m = '0;
  logic        alu_err_m = 1'b0;
  assign alu_calc   = alu_fn(alu_opcode, alu_a, alu_b);
  assign alu_result = alu_res_m;
  assign alu_error  = alu_err_m;
  always @(posedge clk) begin
    alu_res_m <= alu_calc[31:0];
    if (!(alu_opcode inside {3'b010, 3'b011, 3'b100})) alu_err_m <= alu_calc[32];
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Scoreboard: an operation is a countdown to its response, then waits for its handshake.
  bit          live = 1'b0;
  bit          m_idle;
  int          m_ptr, m_gnt, m_last, m_left, sb_g;
  logic [31:0] m_res, m_a, m_b;
  logic        m_err;
  logic [2:0]  m_op;
  logic [NUM_REQ-1:0] sb_rdy, sb_rv;
  logic [32:0] sb_c;

  initial begin : scoreboard
    forever begin
      @(negedge clk);
      sb_g   = m_idle ? rr_pick(m_ptr, req_valid) : -1;
      sb_rdy = '0;
      if (sb_g >= 0 && !rst) sb_rdy[sb_g] = 1'b1;
      sb_rv = '0;
      if (!m_idle && m_left == 0) sb_rv[m_gnt] = 1'b1;
      if (live) begin
        chk("sb_req_ready", 32'(req_ready), 32'(sb_rdy));
        chk("sb_rsp_valid", 32'(rsp_valid), 32'(sb_rv));
        chk("sb_busy", 32'(busy), 32'(!m_idle));
        chk("sb_grant_id", 32'(grant_id), 32'(m_last));
        chk("sb_alu_a", alu_a, m_a);
        chk("sb_alu_b", alu_b, m_b);
        chk("sb_alu_opcode", 32'(alu_opcode), 32'(m_op));
        if (sb_rv != '0) begin
          chk("sb_rsp_result", rsp_result, m_res);
          chk("sb_rsp_error", 32'(rsp_error), 32'(m_err));
        end
      end
      if (rst) begin
        m_idle = 1'b1; m_ptr = 0; m_gnt = 0; m_last = 0; m_left = 0;
        m_res = '0; m_err = 1'b0; m_a = '0; m_b = '0; m_op = '0;
        live = 1'b1;
      end else if (m_idle) begin
        if (sb_g >= 0) begin
          m_idle = 1'b0;
          m_gnt  = sb_g;
          m_last = sb_g;
          if (OPCHK && rop[sb_g] >= 3'd5) begin
            m_left = 0; m_res = '0; m_err = 1'b1;
          end else begin
            sb_c   = alu_fn(rop[sb_g], ra[sb_g], rb[sb_g]);
            m_a    = ra[sb_g]; m_b = rb[sb_g]; m_op = rop[sb_g];
            m_left = ALU_LAT + 1;
            m_res  = sb_c[31:0];
            m_err  = (rop[sb_g] inside {3'b010, 3'b011, 3'b100}) ? 1'b0 : sb_c[32];
          end
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (rsp_ready[m_gnt]) begin
        m_idle = 1'b1;
        m_ptr  = (m_gnt + 1) % NUM_REQ;
      end
    end
  end

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    ra[i] = a; rb[i] = b; rop[i] = op;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rsp_valid == '0 && cyc < 40);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Lone request from requester i; latency counted from the accept cycle.
  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] exp_res, input logic exp_err,
                       input int exp_lat);
    int c;
    @(posedge clk); #1;
    set_slot(i, a, b, op);
    req_valid = '0; req_valid[i] = 1'b1; rsp_ready = '1;
    @(negedge clk);
    chk("op_req_ready", 32'(req_ready), 32'd1 << i);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(c);
    chk("op_latency", 32'(c), 32'(exp_lat));
    chk("op_rsp_valid", 32'(rsp_valid), 32'd1 << i);
    chk("op_result", rsp_result, exp_res);
    chk("op_error", 32'(rsp_error), 32'(exp_err));
  endtask

  int c;

  initial begin : stimulus
    req_valid = '0; rsp_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_result", rsp_result, 32'd0);

    do_op(1, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 3);

    // Everyone requesting: grants rotate 0,1,2,3,0 every ALU_LAT+3 cycles.
    pulse_rst();
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 32'h1234_5670 | i, 32'hFFFF_000F, 3'b010);
    req_valid = '1; rsp_ready = '1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(c);
      chk("rr_interval", 32'(c), 32'd4);
      chk("rr_grant", 32'(oh_idx(rsp_valid)), 32'(k % 4));
      chk("rr_result", rsp_result, 32'h1234_0000 | (k % 4));
      chk("rr_error", 32'(rsp_error), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = '0;

    do_op(2, 32'h7FFF_FFFF, 32'd1, 3'b000, 32'h8000_0000, 1'b1, 3);
    do_op(2, 32'd0, 32'd0, 3'b011, 32'd0, 1'b0, 3);

    // Response back-pressure; other requesters' rsp_ready must be ignored.
    @(posedge clk); #1;
    rsp_ready = '0;
    set_slot(3, 32'd10, 32'd3, 3'b001);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("hold_grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(c);
    chk("hold_latency", 32'(c), 32'd3);
    @(posedge clk); #1;
    set_slot(0, 32'hFF00_FF00, 32'h0F0F_0F0F, 3'b100);
    req_valid = 4'b1001; rsp_ready = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'b1000);
      chk("hold_result", rsp_result, 32'd7);
      chk("hold_error", 32'(rsp_error), 32'd0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = '1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_hold_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    wait_rsp(c);
    chk("after_hold_valid", 32'(rsp_valid), 32'b0001);
    chk("after_hold_result", rsp_result, 32'hF00F_F00F);
    @(posedge clk); #1;
    @(negedge clk);
    chk("regrant_3", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(c);
    chk("regrant_3_result", rsp_result, 32'd7);

    // Reset in the second EXEC cycle drops the operation.
    @(posedge clk); #1;
    set_slot(2, 32'd100, 32'd23, 3'b000);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd0);
    chk("mid_result", rsp_result, 32'd0);
    chk("mid_error", 32'(rsp_error), 32'd0);
    chk("mid_alu_a", alu_a, 32'd0);
    chk("mid_alu_b", alu_b, 32'd0);
    chk("mid_grant_id", 32'(grant_id), 32'd0);
    do_op(2, 32'd100, 32'd23, 3'b000, 32'd123, 1'b0, 3);

`ifdef ALU_RR_SCHED_OPCHK_EN
    do_op(1, 32'd1, 32'd1, 3'b110, 32'd0, 1'b1, 1);
    chk("opchk_alu_opcode", 32'(alu_opcode), 32'd0);
`else
    do_op(1, 32'd1, 32'd1, 3'b110, 32'd0, 1'b1, 3);
    chk("opchk_alu_opcode", 32'(alu_opcode), 32'd6);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
